dvs_event_sequencer: RTL
========================

# dvs_event_sequencer

- Sits directly downstream of the DVS AER receiver.
- Turns the receiver's word stream (Y-address words, then X-address words) into complete pixel events: x, y, polarity and an optional timestamp.
- Buffers events in a small FIFO and presents them on a valid/ready interface toward the RAVENS-side logic.
- Applies backpressure to the receiver when the FIFO nears capacity; malformed, out-of-range and overflow events are dropped and counted.

## Interface
Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥ 2
- DROP_CNT_W, 8, width of saturating drop counter
- TS_WIDTH, 16, timestamp width (used only with DVS_EVENT_TIMESTAMP_EN)

Ports:
- clk  in  1  interface clock, period CLK_PERIOD_NS
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle pulse: receiver captured a new word
- aer_rx  in  10  captured AER word
- xsel_rx  in  1  1 = X word, 0 = Y word
- rx_hold  out  1  stall request to receiver: do not complete next handshake
- evt_valid  out  1  event available at FIFO head
- evt_ready  in  1  consumer accepts head event
- evt_x  out  9  head event X address
- evt_y  out  9  head event Y address
- evt_pol  out  1  head event polarity
- evt_ts  out  TS_WIDTH  head event timestamp (port exists only with DVS_EVENT_TIMESTAMP_EN)
- drop_cnt  out  DROP_CNT_W  saturating count of dropped words/events
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Word decode:
  - Y word: y = aer_rx[8:0]; aer_rx[9] ignored.
  - X word: x = aer_rx[9:1], pol = aer_rx[0].
- FSM, two states:
  - NO_ROW (reset state).
  - ROW: Y register valid.
- Y word, any state:
  - y < DVS_HEIGHT_PXLS: load row register, go to ROW.
  - Otherwise: go to NO_ROW, increment drop_cnt.
- X word in NO_ROW: drop, increment drop_cnt, stay in NO_ROW.
- X word in ROW:
  - x ≥ DVS_WIDTH_PXLS: drop, increment drop_cnt.
  - Else if a push is possible: push {x, row_y, pol[, ts]}.
  - Else: drop, increment drop_cnt.
  - State stays ROW in all three cases; the same row serves consecutive X words.
- Push is possible when fifo_level < FIFO_DEPTH, or when full with a pop in the same cycle.
- Pop occurs when evt_valid && evt_ready.
- drop_cnt saturates at all-ones and never wraps.
- rx_hold = (fifo_level ≥ FIFO_DEPTH−1), registered.
- Words arriving while rx_hold is high are still processed. The receiver honouring rx_hold is what makes overflow drops rare, not impossible.
- Reset mid-operation: FIFO flushed, FSM → NO_ROW, counters cleared, timestamp counter cleared. Any partially received row is discarded.

## Timing
- Reset values:
  - rx_hold 0, evt_valid 0, evt_x/evt_y/evt_pol 0, drop_cnt 0, fifo_level 0, evt_ts 0.
  - FSM in NO_ROW.
- FIFO storage is registered; the head is shown from the storage read pointer.
- Latency: rx_valid X word at edge N → evt_valid high after edge N+1.
- Consecutive rx_valid on back-to-back cycles are supported.
- FIFO reporting:
  - evt_valid = (fifo_level ≠ 0).
  - Head outputs stable while evt_valid && !evt_ready.
- Same-cycle push and pop: level unchanged.
  - When full, the pushed event is accepted.
  - When empty, no pop is possible; the push lands and appears next cycle.
- fifo_level and rx_hold update one cycle after the causing push/pop.
- Pointers wrap modulo FIFO_DEPTH.

## Configuration
- DVS_EVENT_TIMESTAMP_EN defined:
  - Free-running TS_WIDTH-bit counter, +1 per clk, wraps to 0.
  - The value at the cycle of rx_valid for the X word is stored with the event and shown on evt_ts.
- Undefined:
  - No counter, no evt_ts port.
  - FIFO entries are 19 bits wide.

## Structure
- Shared package (dvs_ravens_pkg) holds:
  - DVS_WIDTH_PXLS, DVS_HEIGHT_PXLS, CLK_PERIOD_NS (both pixel constants < 512).
  - typedef struct packed dvs_event_t {x[8:0], y[8:0], pol[, ts]}.
  - typedef enum seq_state_t {NO_ROW, ROW}.
- One sub-module: dvs_event_fifo.
  - Parameterised synchronous FIFO with fall-through head, level output and simultaneous push/pop when full.
  - Instanced once.

## Test plan
1. Reset, then Y word 10'h00A, then X word {9'd5, 1'b1} → one event x=5, y=10, pol=1; evt_valid rises the cycle after the X word edge; drop_cnt=0.
2. Y=10'h014, then X words x=3 pol=0, x=7 pol=1 with evt_ready=1 → two events (3,20,0), (7,20,1) in order.
3. X word with no prior Y after reset → no event, drop_cnt=1, FSM stays NO_ROW.
4. evt_ready=0, Y=1, then five X words x=0..4 with FIFO_DEPTH=4:
   - rx_hold high once level reaches 3.
   - Fifth word dropped, drop_cnt=1, level=4.
   - Then evt_ready=1 → events x=0..3 in order.
5. Y word 9'h1FF → drop_cnt=1, FSM NO_ROW; a following X word is also dropped, drop_cnt=2.
6. Assert rst_n low for one cycle with FIFO at level 2 → level 0, evt_valid 0, drop_cnt 0 immediately. With DVS_EVENT_TIMESTAMP_EN, the event pushed 100 cycles after reset release carries evt_ts=100±1.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: sensor geometry, interface clock and event/FSM types shared by the DVS sequencer blocks
package dvs_ravens_pkg;
  localparam int DVS_WIDTH_PXLS = 346;
  localparam int DVS_HEIGHT_PXLS = 260;
  localparam int CLK_PERIOD_NS = 10;
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       pol;
  } dvs_event_t;
  typedef enum logic {NO_ROW, ROW} seq_state_t;
endpackage

// File: rtl/dvs_event_fifo.sv
// dvs_event_fifo: synchronous FIFO with fall-through head, level output and push+pop when full
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and data (ignored when no room)
//   ready           consumer accepts head; pops when valid
//   can_push        room for a push this cycle (counts a same-cycle pop)
//   valid, head     head present and its data (read straight from storage)
//   level           occupancy
//   hold            registered level >= DEPTH-1
module dvs_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 19,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic          can_push,
  output logic          valid,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          hold
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, wr;
  logic [LW-1:0] level_nx;
  assign valid = level != '0;
  assign pop = valid && ready;
  assign can_push = level < LW'(DEPTH) || pop;
  assign wr = push && can_push;
  assign level_nx = level + LW'(wr) - LW'(pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      hold <= 1'b0;
    end else begin
      if (wr) mem[wr_ptr] <= din;
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level_nx;
      hold <= level_nx >= LW'(DEPTH - 1);
    end
  end
endmodule

// File: rtl/dvs_event_sequencer.sv
// dvs_event_sequencer: assembles AER Y/X words into pixel events and queues them on a valid/ready port
//   Optional feature macro: DVS_EVENT_TIMESTAMP_EN (adds timestamp counter and evt_ts port)
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_valid, aer_rx, xsel_rx   receiver word strobe, word, X/Y select
//   rx_hold                     stall request to the receiver
//   evt_valid, evt_ready        event handshake
//   evt_x, evt_y, evt_pol       head event fields; evt_ts head timestamp (feature only)
//   drop_cnt                    saturating count of dropped words/events
//   fifo_level                  current FIFO occupancy
module dvs_event_sequencer
  import dvs_ravens_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8,
  parameter int TS_WIDTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [9:0]            aer_rx,
  input  logic                  xsel_rx,
  output logic                  rx_hold,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [8:0]            evt_x,
  output logic [8:0]            evt_y,
  output logic                  evt_pol,
`ifdef DVS_EVENT_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]   evt_ts,
`endif
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [LW-1:0]         fifo_level
);
`ifdef DVS_EVENT_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int W = $bits(dvs_event_t) + TS_EN * TS_WIDTH;
  seq_state_t state;
  logic [8:0] row_y, x_w, y_w;
  logic is_x, is_y, y_ok, x_ok, push, can_push, drop;
  dvs_event_t ev, h;
  logic [W-1:0] din, head;
  assign y_w = aer_rx[8:0];
  assign x_w = aer_rx[9:1];
  assign is_x = rx_valid && xsel_rx;
  assign is_y = rx_valid && !xsel_rx;
  assign y_ok = y_w < 9'(DVS_HEIGHT_PXLS);
  assign x_ok = x_w < 9'(DVS_WIDTH_PXLS);
  assign push = is_x && state == ROW && x_ok;
  // covers bad Y, X without a row, out-of-range X, and X with no FIFO room
  assign drop = (is_y && !y_ok) || (is_x && !(push && can_push));
  assign ev = '{x: x_w, y: row_y, pol: aer_rx[0]};
`ifdef DVS_EVENT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  assign din = {ev, ts_cnt};
  assign {h, evt_ts} = head;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else ts_cnt <= ts_cnt + 1'b1;
  end
`else
  assign din = ev;
  assign h = head;
`endif
  assign evt_x = h.x;
  assign evt_y = h.y;
  assign evt_pol = h.pol;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NO_ROW;
      row_y <= '0;
      drop_cnt <= '0;
    end else begin
      if (is_y) state <= y_ok ? ROW : NO_ROW;
      if (is_y && y_ok) row_y <= y_w;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  dvs_event_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(din),
    .ready(evt_ready),
    .can_push(can_push),
    .valid(evt_valid),
    .head(head),
    .level(fifo_level),
    .hold(rx_hold)
  );
endmodule
